ifetch_stage: RTL

Instruction fetch stage that sits directly upstream of the main control decoder. It holds the PC and issues word fetches to instruction memory over a valid/ready request channel with an in-order response channel. Returned instructions are buffered in a small FIFO and presented to decode with their PC and opcode field. Branch redirects flush the stage and discard stale in-flight responses.

---
 rtl/ifetch_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: issues word fetches over a valid/ready channel, buffers the
// in-order responses with their PCs, and presents them to decode; redirects flush it.
module ifetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic [6:0]      id_opcode
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [CW:0]     DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] NOP       = XLEN'(32'h0000_0013);

  logic            rst_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pcq_wr_q, pcq_wr_d;
  logic [PW-1:0]   pcq_rd_q, pcq_rd_d;

  // Instruction FIFO plus the PC queue that shadows every accepted request.
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] pcq_mem_q   [DEPTH];

  logic [CW:0] occ;
  logic        req_fire;
  logic        push;
  logic        pop;

  // Occupancy counts requests in flight plus buffered entries, so every response has a slot.
  assign occ            = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = !rst_q && !redirect_valid && (occ < DEPTH_OCC);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid  = (count_q != '0);
  assign id_pc     = id_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign id_instr  = id_valid ? instr_mem_q[rd_ptr_q] : NOP;
  assign id_opcode = id_instr[6:0];

  assign push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign pop  = id_valid && id_ready && !redirect_valid;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    count_d    = count_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pcq_wr_d   = pcq_wr_q;
    pcq_rd_d   = pcq_rd_q;

    // Stale responses still retire their PC-queue slot, so these pointers never flush.
    if (req_fire)       pcq_wr_d = pcq_wr_q + PW'(1);
    if (imem_rsp_valid) pcq_rd_d = pcq_rd_q + PW'(1);

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      drop_d     = inflight_q - CW'(imem_rsp_valid);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      rst_q      <= 1'b1;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
    end else begin
      rst_q      <= 1'b0;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
    end
  end

  // NOTE: storage arrays are not reset; only the pointers and count are, and id_valid
  // gates the outputs so an unwritten entry is never presented.
  always_ff @(posedge clk) begin
    if (!rst && req_fire) pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
    if (!rst && push) begin
      instr_mem_q[wr_ptr_q] <= imem_rsp_data;
      pc_mem_q[wr_ptr_q]    <= pcq_mem_q[pcq_rd_q];
    end
  end

`ifndef SYNTHESIS
  a_counts: assert property (@(posedge clk) disable iff (rst)
    (drop_q <= inflight_q) && (inflight_q <= DEPTH_C) && (count_q <= DEPTH_C) && (occ <= DEPTH_OCC));
  a_rsp_needs_req: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (inflight_q != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> ((count_q != DEPTH_C) || pop));
`endif

endmodule
